// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - LFSR random generator with Fibonacci/Galois stepping and range-limited draws
// A draw re-steps the LFSR until the low OUT_W bits fall within LIMIT, or falls back to LIMIT.
module lfsr_rng #(
   parameter int              WIDTH     = 16,
   parameter int              OUT_W     = 5,
   parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
   parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
   parameter int              LIMIT     = 23,
   parameter int              MAX_TRIES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req,
   output logic             busy,
   output logic             valid,
   output logic [OUT_W-1:0] data,
   output logic [WIDTH-1:0] state_out,
   output logic             lockup
);

   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_DRAW = 1'b1;

   localparam logic [OUT_W-1:0] LIMIT_V  = OUT_W'(LIMIT);
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

   logic [0:0]       fsm;
   logic [TRY_W-1:0] tries;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] step_raw;
   logic [WIDTH-1:0] step_next;
   logic             step_zero;
   logic [OUT_W-1:0] cand;

   always_comb begin
      step_raw = '0;
      if (mode)
         step_raw = (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
      else
         step_raw = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      // A step that lands on the all-zero state would stick forever; recover to SEED.
      step_zero = (step_raw == '0);
      step_next = step_zero ? SEED : step_raw;
      cand      = step_next[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm    <= S_IDLE;
         tries  <= '0;
         lfsr   <= SEED;
         data   <= '0;
         valid  <= 1'b0;
         lockup <= 1'b0;
      end else begin
         valid  <= 1'b0;
         lockup <= 1'b0;
         if (load) begin
            fsm   <= S_IDLE;
            tries <= '0;
            if (seed_in == '0) begin
               lfsr   <= SEED;
               lockup <= 1'b1;
            end else begin
               lfsr <= seed_in;
            end
         end else if (fsm == S_DRAW) begin
            lfsr   <= step_next;
            lockup <= step_zero;
            if (cand <= LIMIT_V) begin
               data  <= cand;
               valid <= 1'b1;
               fsm   <= S_IDLE;
            end else if (tries == LAST_TRY) begin
               data  <= LIMIT_V;
               valid <= 1'b1;
               fsm   <= S_IDLE;
            end else begin
               tries <= tries + 1'b1;
            end
         end else if (req) begin
            // The request edge only arms the draw; the first step happens next edge.
            fsm   <= S_DRAW;
            tries <= '0;
         end else if (en) begin
            lfsr   <= step_next;
            lockup <= step_zero;
         end
      end
   end

   assign busy      = (fsm == S_DRAW);
   assign state_out = lfsr;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - randomized self-checking bench for lfsr_rng
// Reference model predicts whole draws and free-run sequences arithmetically.
module tb_lfsr_rng;

   localparam int          LIM    = 23;
   localparam int          MT     = 8;
   localparam int unsigned TAPS_R = 32'hB400;
   localparam int unsigned SEED_R = 32'hACE1;

   logic        clk, rst_n, en, mode, load, req;
   logic [15:0] seed_in;
   logic        busy, valid, lockup;
   logic [4:0]  data;
   logic [15:0] state_out;

   logic        fb_req, fb_busy, fb_valid, fb_lockup;
   logic [4:0]  fb_data;
   logic [15:0] fb_state;

   int          n_checks = 0;
   int          n_pass   = 0;
   int unsigned m_state, m_data;

   lfsr_rng u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
      .seed_in(seed_in), .req(req), .busy(busy), .valid(valid),
      .data(data), .state_out(state_out), .lockup(lockup)
   );

   lfsr_rng #(.LIMIT(1), .MAX_TRIES(1)) u_fb (
      .clk(clk), .rst_n(rst_n), .en(1'b0), .mode(1'b0), .load(1'b0),
      .seed_in(16'h0000), .req(fb_req), .busy(fb_busy), .valid(fb_valid),
      .data(fb_data), .state_out(fb_state), .lockup(fb_lockup)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned ref_step(input int unsigned s, input bit m);
      int unsigned n;
      if (m) n = (s >> 1) ^ (((s & 1) != 0) ? TAPS_R : 0);
      else   n = ((s << 1) & 32'hFFFF) | ($countones(s & TAPS_R) & 1);
      return (n == 0) ? SEED_R : n;
   endfunction

   task automatic predict_draw(input int unsigned s0, input bit m, output int unsigned d,
                               output int unsigned n, output int unsigned s);
      s = s0;
      d = LIM;
      n = MT;
      for (int t = 0; t < MT; t++) begin
         s = ref_step(s, m);
         if ((s & 31) <= LIM) begin
            d = s & 31;
            n = t + 1;
            break;
         end
      end
   endtask

   task automatic do_draw(input bit m);
      int unsigned exp_d, exp_n, exp_s;
      int          got_n;
      predict_draw(m_state, m, exp_d, exp_n, exp_s);
      mode = m; req = 1'b1; tick(); req = 1'b0;
      chk("draw_busy", 32'(busy), 1);
      got_n = 0;
      for (int c = 1; c <= MT + 2; c++) begin
         en  = 1'($urandom_range(0, 1));
         req = 1'($urandom_range(0, 1));
         tick();
         if (valid) begin
            got_n = c;
            break;
         end
      end
      req = 1'b0; en = 1'b0;
      chk("draw_latency", 32'(got_n), exp_n);
      chk("draw_data", 32'(data), exp_d);
      chk("draw_state", 32'(state_out), exp_s);
      m_state = exp_s;
      m_data  = exp_d;
      tick();
      chk("draw_valid_pulse", 32'(valid), 0);
      chk("draw_idle", 32'(busy), 0);
   endtask

   task automatic free_run(input int n);
      for (int i = 0; i < n; i++) begin
         en   = 1'($urandom_range(0, 1));
         mode = 1'($urandom_range(0, 1));
         if (en) m_state = ref_step(m_state, mode);
         tick();
         chk("free_state", 32'(state_out), m_state);
         chk("free_lockup", 32'(lockup), 0);
      end
      en = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] s, input bit with_req);
      seed_in = s; load = 1'b1; req = with_req;
      tick();
      load = 1'b0; req = 1'b0;
      m_state = (s == 16'h0) ? SEED_R : 32'(s);
      chk("load_state", 32'(state_out), m_state);
      chk("load_lockup", 32'(lockup), (s == 16'h0) ? 1 : 0);
      chk("load_busy", 32'(busy), 0);
      tick();
      chk("load_lockup_clear", 32'(lockup), 0);
      chk("load_req_dropped", 32'(busy), 0);
   endtask

   task automatic find_reject_seed(output logic [15:0] s);
      int unsigned cand;
      s = 16'h1234;
      for (int i = 0; i < 1000; i++) begin
         cand = 32'($urandom_range(1, 65535));
         if ((ref_step(cand, 1'b0) & 31) > LIM) begin
            s = 16'(cand);
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] rs;
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; req = 1'b0; fb_req = 1'b0;
      seed_in = 16'h0;
      #12;
      chk("rst_state", 32'(state_out), SEED_R);
      chk("rst_data", 32'(data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_lockup", 32'(lockup), 0);
      tick();
      rst_n = 1'b1;
      m_state = SEED_R;
      m_data  = 0;

      // Fallback instance: candidate 3 exceeds LIMIT=1 on its only try.
      fb_req = 1'b1; tick(); fb_req = 1'b0;
      chk("fb_busy", 32'(fb_busy), 1);
      tick();
      chk("fb_valid", 32'(fb_valid), 1);
      chk("fb_data", 32'(fb_data), 1);
      chk("fb_state", 32'(fb_state), 32'h59C3);
      tick();
      chk("fb_valid_pulse", 32'(fb_valid), 0);

      en = 1'b1; mode = 1'b0; tick(); en = 1'b0;
      chk("fib_step", 32'(state_out), 32'h59C3);
      do_load(16'hACE1, 1'b0);
      en = 1'b1; mode = 1'b1; tick(); en = 1'b0;
      chk("gal_step", 32'(state_out), 32'hE270);

      do_load(16'hACE1, 1'b0);
      do_draw(1'b0);
      chk("draw_ace1_data", 32'(data), 3);
      chk("draw_ace1_state", 32'(state_out), 32'h59C3);

      do_load(16'h0000, 1'b0);
      do_load(16'h0001, 1'b1);

      // Load aborts a multi-step draw and leaves data untouched.
      find_reject_seed(rs);
      do_load(rs, 1'b0);
      mode = 1'b0; req = 1'b1; tick(); req = 1'b0;
      tick();
      chk("abort_busy_mid", 32'(busy), 1);
      chk("abort_valid_mid", 32'(valid), 0);
      seed_in = 16'h1234; load = 1'b1; tick(); load = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(valid), 0);
      chk("abort_data", 32'(data), m_data);
      chk("abort_state", 32'(state_out), 32'h1234);
      m_state = 32'h1234;
      tick();
      chk("abort_no_late_valid", 32'(valid), 0);

      // Asynchronous reset mid-draw.
      do_load(rs, 1'b0);
      req = 1'b1; tick(); req = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_busy", 32'(busy), 0);
      chk("rstmid_valid", 32'(valid), 0);
      chk("rstmid_state", 32'(state_out), SEED_R);
      chk("rstmid_data", 32'(data), 0);
      tick();
      rst_n = 1'b1;
      m_state = SEED_R;
      m_data  = 0;
      tick();
      chk("rstmid_no_valid", 32'(valid), 0);

      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 3))
            0: free_run(int'($urandom_range(1, 6)));
            1: do_load(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                       1'($urandom_range(0, 1)));
            default: do_draw(1'($urandom_range(0, 1)));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lfsr_rng.md
LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 Parameter WIDTH, default 16, sets the LFSR state width; legal range 3..32.
REQ-002 Parameter OUT_W, default 5, sets the width of the random output; OUT_W SHALL be less than or equal to WIDTH.
REQ-003 Parameter TAPS, default 16'hB400, is the tap/feedback mask, WIDTH bits wide.
REQ-004 Parameter SEED, default 16'hACE1, is the reset and lockup-recovery state; it SHALL be nonzero.
REQ-005 Parameter LIMIT, default 23, is the largest legal output value; LIMIT SHALL be less than 2^OUT_W.
REQ-006 Parameter MAX_TRIES, default 8, is the maximum number of draw steps per request; legal range 1..255.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  reset, asynchronous and active-low.
REQ-009 en  in  1  free-run enable; steps the LFSR once per cycle while the FSM is IDLE.
REQ-010 mode  in  1  step mode: 0 = Fibonacci, 1 = Galois; may change on any cycle.
REQ-011 load  in  1  seed load strobe.
REQ-012 seed_in  in  WIDTH  seed value, captured when load=1.
REQ-013 req  in  1  request for one range-limited draw.
REQ-014 busy  out  1  high while a draw is in progress.
REQ-015 valid  out  1  one-cycle pulse when data is updated by a draw.
REQ-016 data  out  OUT_W  last drawn value, held between draws.
REQ-017 state_out  out  WIDTH  current LFSR state.
REQ-018 lockup  out  1  one-cycle pulse when a zero state is replaced by SEED.

Function
REQ-019 The Fibonacci step SHALL be: fb = XOR of (state AND TAPS); next = {state[WIDTH-2:0], fb}.
REQ-020 The Galois step SHALL be: next = (state >> 1) XOR (state[0] ? TAPS : 0).
REQ-021 Update priority per edge SHALL be: load > draw step > en step > hold.
REQ-022 On load=1 the state SHALL become seed_in next edge; if seed_in == 0 it SHALL become SEED, with lockup=1 for that one cycle.
REQ-023 FSM states SHALL be IDLE and DRAW.
REQ-024 In IDLE with req=1 and load=0: go to DRAW, busy=1, try counter cleared to 0, no LFSR step on that edge.
REQ-025 Each DRAW edge: one LFSR step regardless of en; candidate = next[OUT_W-1:0].
REQ-026 If candidate <= LIMIT (DRAW edge): data <= candidate, valid=1 for one cycle, return to IDLE, busy=0.
REQ-027 If candidate > LIMIT and try count == MAX_TRIES-1 (DRAW edge): data <= LIMIT (fallback), valid=1, return to IDLE.
REQ-028 Otherwise (DRAW edge): increment try count and stay in DRAW.
REQ-029 Latency: req sampled at edge E0; first step at E0+1; valid at the earliest after E0+1 and at the latest after E0+MAX_TRIES.
REQ-030 req while busy=1 SHALL be ignored and not queued.
REQ-031 load=1 during DRAW SHALL abort the draw: return to IDLE, no valid, data unchanged, seed loaded per REQ-022.
REQ-032 req and load high together in IDLE: load wins; the request is dropped.
REQ-033 en SHALL have no effect during DRAW.
REQ-034 The try counter SHALL be ceil(log2(MAX_TRIES+1)) bits and never wrap.

Reset
REQ-035 When rst_n=0, immediately and independent of clk: state=SEED, FSM=IDLE, try count=0, data=0, valid=0, busy=0, lockup=0.
REQ-036 Reset asserted mid-draw SHALL cancel the draw with no valid pulse.

Verification
REQ-037 Reset (defaults): state_out=16'hACE1, data=0, busy=0, valid=0, lockup=0.
REQ-038 mode=0, en=1 for 1 cycle from ACE1 -> state_out=16'h59C3; separately, mode=1 for 1 cycle from ACE1 -> 16'hE270.
REQ-039 mode=0, req pulse from ACE1 -> busy for 1 cycle, data=3, valid for 1 cycle 2 cycles after the req cycle, state_out=16'h59C3.
REQ-040 LIMIT=1, MAX_TRIES=1, mode=0, req from ACE1 -> candidate 3 rejected, data=1 (fallback), valid after 1 step.
REQ-041 load=1 with seed_in=0 -> state_out=16'hACE1, lockup=1 for 1 cycle; load with seed_in=16'h0001 -> state_out=16'h0001.
REQ-042 Draw in progress, then load=1 or rst_n=0 mid-draw -> busy=0, no valid, data keeps its prior value.
